// File: rtl/ddr_pkg.sv
// ddr_pkg: shared command encodings, FSM states and err bit
// positions for the x16 DDR responder.
package ddr_pkg;

  localparam logic [2:0] CMD_ACT   = 3'b011;
  localparam logic [2:0] CMD_READ  = 3'b101;
  localparam logic [2:0] CMD_WRITE = 3'b100;
  localparam logic [2:0] CMD_PRE   = 3'b010;
  localparam logic [2:0] CMD_REF   = 3'b001;
  localparam logic [2:0] CMD_MRS   = 3'b000;
  localparam logic [2:0] CMD_NOP   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_WAIT,
    ST_WR_BURST,
    ST_RD_WAIT,
    ST_RD_BURST
  } state_t;

  localparam int ERR_CLOSED   = 0;
  localparam int ERR_ACT_OPEN = 1;
  localparam int ERR_BUSY     = 2;
  localparam int ERR_REF_OPEN = 3;

endpackage

// File: rtl/ddr_resp_mem.sv
// ddr_resp_mem: single-port synchronous word store, 16-bit words
// with per-byte write enables; read data appears one clock later.
module ddr_resp_mem
  import ddr_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [1:0]    be,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      if (be[0]) mem[addr][7:0]  <= wdata[7:0];
      if (be[1]) mem[addr][15:8] <= wdata[15:8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ddr_x16_responder.sv
// ddr_x16_responder: device end of the x16 DDR interface; bank
// table, single outstanding 8-beat burst, registered DQ/DQS drive.
module ddr_x16_responder
  import ddr_pkg::*;
#(
  parameter int CL     = 3,
  parameter int WL     = 1,
  parameter int ROW_W  = 13,
  parameter int COL_W  = 10,
  parameter int MEM_AW = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs_n,
  input  logic             ras_n,
  input  logic             cas_n,
  input  logic             we_n,
  input  logic [1:0]       ba,
  input  logic [ROW_W-1:0] addr,
  input  logic [15:0]      dq_in,
  input  logic [1:0]       dm_in,
  output logic [15:0]      dq_out,
  output logic             dq_oe,
  output logic [1:0]       dqs_out,
  output logic             dqs_oe,
  output logic [3:0]       err
);

  localparam int FULL_W = 2 + ROW_W + COL_W;
  localparam int BASE_W = MEM_AW - 3;
  localparam logic [3:0] CL_N = 4'(CL);
  localparam logic [3:0] CL_P = 4'(CL - 1);
  localparam logic [3:0] WL_N = 4'(WL);

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic [3:0] open_q, open_d;
  logic [3:0][ROW_W-1:0] row_q, row_d;
  logic [3:0] err_d;
  logic [15:0] dq_d;
  logic dq_oe_d, dqs_oe_d;
  logic [1:0] dqs_d;

  logic [2:0] cmd;
  logic [FULL_W-1:0] full_addr;
  logic unused_bits;
  logic mem_we;
  logic [2:0] mem_beat;
  logic [MEM_AW-1:0] mem_addr;
  logic [15:0] mem_rdata;

  assign cmd = cs_n ? CMD_NOP : {ras_n, cas_n, we_n};
  assign full_addr = {ba, row_q[ba], addr[COL_W-1:3], 3'b000};
  assign unused_bits = ^{full_addr[FULL_W-1:MEM_AW], full_addr[2:0]};
  assign mem_addr = {base_q, mem_beat};

  ddr_resp_mem #(
    .AW(MEM_AW)
  ) u_mem (
    .clk  (clk),
    .addr (mem_addr),
    .we   (mem_we),
    .be   (~dm_in),
    .wdata(dq_in),
    .rdata(mem_rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    open_d   = open_q;
    row_d    = row_q;
    err_d    = err;
    dq_d     = dq_out;
    dq_oe_d  = dq_oe;
    dqs_d    = dqs_out;
    dqs_oe_d = dqs_oe;
    mem_we   = 1'b0;
    mem_beat = 3'd0;

    if (state_q != ST_IDLE && cmd != CMD_NOP)
      err_d[ERR_BUSY] = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        case (cmd)
          CMD_ACT: begin
            if (open_q[ba]) err_d[ERR_ACT_OPEN] = 1'b1;
            open_d[ba] = 1'b1;
            row_d[ba]  = addr;
          end
          CMD_PRE: begin
            if (addr[10]) open_d = 4'b0000;
            else open_d[ba] = 1'b0;
          end
          CMD_REF: begin
            if (|open_q) err_d[ERR_REF_OPEN] = 1'b1;
          end
          CMD_READ, CMD_WRITE: begin
            if (!open_q[ba]) begin
              err_d[ERR_CLOSED] = 1'b1;
            end else begin
              state_d = (cmd == CMD_READ) ? ST_RD_WAIT : ST_WR_WAIT;
              cnt_d   = 4'd1;
              base_d  = full_addr[MEM_AW-1:3];
            end
          end
          default: ;
        endcase
      end
      ST_WR_WAIT: begin
        // beat 0 lands on the edge WL clocks after the command
        if (cnt_q == WL_N) begin
          mem_we  = 1'b1;
          state_d = ST_WR_BURST;
          cnt_d   = 4'd1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_WR_BURST: begin
        if (cnt_q == 4'd8) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          mem_we   = 1'b1;
          mem_beat = cnt_q[2:0];
          cnt_d    = cnt_q + 4'd1;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == CL_P) begin
          dqs_oe_d = 1'b1;
          dqs_d    = 2'b00;
        end
        // beat 0 prefetched on the preamble edge, beat 1 fetched now
        if (cnt_q == CL_N) begin
          mem_beat = 3'd1;
          dq_d     = mem_rdata;
          dq_oe_d  = 1'b1;
          dqs_d    = 2'b11;
          state_d  = ST_RD_BURST;
          cnt_d    = 4'd1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RD_BURST: begin
        if (cnt_q == 4'd8) begin
          dq_d     = 16'h0000;
          dq_oe_d  = 1'b0;
          dqs_d    = 2'b00;
          dqs_oe_d = 1'b0;
          state_d  = ST_IDLE;
          cnt_d    = 4'd0;
        end else begin
          mem_beat = cnt_q[2:0] + 3'd1;
          dq_d     = mem_rdata;
          dqs_d    = cnt_q[0] ? 2'b00 : 2'b11;
          cnt_d    = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      base_q  <= '0;
      open_q  <= 4'b0000;
      row_q   <= '0;
      err     <= 4'b0000;
      dq_out  <= 16'h0000;
      dq_oe   <= 1'b0;
      dqs_out <= 2'b00;
      dqs_oe  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      open_q  <= open_d;
      row_q   <= row_d;
      err     <= err_d;
      dq_out  <= dq_d;
      dq_oe   <= dq_oe_d;
      dqs_out <= dqs_d;
      dqs_oe  <= dqs_oe_d;
    end
  end

endmodule

// File: tb/tb_ddr_x16_responder.sv
// tb_ddr_x16_responder: vector table of bank/burst operations with a
// word-store model and read-beat scoreboard, plus corner sequences.
module tb_ddr_x16_responder;
  import ddr_pkg::*;

  localparam int CL = 3;
  localparam int WL = 1;
  localparam int ROW_W = 13;
  localparam int COL_W = 10;
  localparam int MEM_AW = 10;

  localparam int OP_ACT = 0;
  localparam int OP_WR  = 1;
  localparam int OP_RD  = 2;
  localparam int OP_PRE = 3;
  localparam int OP_REF = 4;
  localparam int NV = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs_n, ras_n, cas_n, we_n;
  logic [1:0] ba;
  logic [ROW_W-1:0] addr;
  logic [15:0] dq_in;
  logic [1:0] dm_in;
  logic [15:0] dq_out;
  logic dq_oe;
  logic [1:0] dqs_out;
  logic dqs_oe;
  logic [3:0] err;

  always #5 clk = ~clk;

  ddr_x16_responder #(
    .CL(CL), .WL(WL), .ROW_W(ROW_W),
    .COL_W(COL_W), .MEM_AW(MEM_AW)
  ) dut (
    .clk(clk), .rst(rst),
    .cs_n(cs_n), .ras_n(ras_n),
    .cas_n(cas_n), .we_n(we_n),
    .ba(ba), .addr(addr),
    .dq_in(dq_in), .dm_in(dm_in),
    .dq_out(dq_out), .dq_oe(dq_oe),
    .dqs_out(dqs_out), .dqs_oe(dqs_oe),
    .err(err)
  );

  typedef struct {
    int op;
    logic [1:0] ba;
    logic [ROW_W-1:0] adr;
    logic [7:0][15:0] data;
    logic [7:0][1:0] dm;
    logic [3:0] exp_err;
  } vec_t;

  typedef struct packed {
    logic [15:0] dq;
    logic [1:0] dqs;
  } beat_t;

  vec_t vecs[NV];
  beat_t sb[$];
  logic [15:0] model[int];
  logic [ROW_W-1:0] mrow[4];
  logic mopen[4];
  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int waddr(logic [1:0] b, logic [ROW_W-1:0] r,
                               logic [ROW_W-1:0] a, int k);
    longint full;
    full = (longint'(b) << (ROW_W + COL_W))
         | (longint'(r) << COL_W)
         | (longint'(a[COL_W-1:0]) & ~longint'(7))
         | longint'(k);
    return int'(full & ((longint'(1) << MEM_AW) - 1));
  endfunction

  function automatic logic [15:0] mread(int ad);
    return model.exists(ad) ? model[ad] : 16'h0000;
  endfunction

  function automatic vec_t mk(int op, logic [1:0] b, logic [ROW_W-1:0] a,
                              logic [7:0][15:0] d, logic [7:0][1:0] m,
                              logic [3:0] e);
    vec_t v;
    v.op = op; v.ba = b; v.adr = a;
    v.data = d; v.dm = m; v.exp_err = e;
    return v;
  endfunction

  always @(negedge clk) begin
    beat_t e;
    if (!rst && dq_oe) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected actual dq_oe=1 dq=%0h required dq_oe=0",
                 dq_out);
      end else begin
        e = sb.pop_front();
        chk("rd_dq", dq_out, e.dq);
        chk("rd_dqs", dqs_out, e.dqs);
        chk("rd_dqs_oe", dqs_oe, 1'b1);
      end
    end
  end

  task automatic drive_cmd(logic [2:0] c, logic [1:0] b, logic [ROW_W-1:0] a);
    cs_n = 1'b0;
    {ras_n, cas_n, we_n} = c;
    ba = b;
    addr = a;
    @(posedge clk); #1;
    cs_n = 1'b1;
    {ras_n, cas_n, we_n} = CMD_NOP;
  endtask

  task automatic do_write(logic [1:0] b, logic [ROW_W-1:0] a,
                          logic [7:0][15:0] d, logic [7:0][1:0] m, int inj);
    logic legal;
    int ad;
    logic [15:0] o;
    legal = mopen[b];
    drive_cmd(CMD_WRITE, b, a);
    repeat (WL - 1) begin @(posedge clk); #1; end
    for (int k = 0; k < 8; k++) begin
      dq_in = d[k];
      dm_in = m[k];
      if (k == inj) begin
        cs_n = 1'b0;
        {ras_n, cas_n, we_n} = CMD_ACT;
        ba = 2'd3;
        addr = 13'h0077;
      end
      @(posedge clk); #1;
      cs_n = 1'b1;
      {ras_n, cas_n, we_n} = CMD_NOP;
    end
    @(posedge clk); #1;
    if (legal) begin
      for (int k = 0; k < 8; k++) begin
        ad = waddr(b, mrow[b], a, k);
        o = mread(ad);
        if (!m[k][0]) o[7:0] = d[k][7:0];
        if (!m[k][1]) o[15:8] = d[k][15:8];
        model[ad] = o;
      end
    end
  endtask

  task automatic push_beats(logic [1:0] b, logic [ROW_W-1:0] a, int n);
    beat_t e;
    for (int k = 0; k < n; k++) begin
      e.dq = mread(waddr(b, mrow[b], a, k));
      e.dqs = k[0] ? 2'b00 : 2'b11;
      sb.push_back(e);
    end
  endtask

  task automatic do_read(logic [1:0] b, logic [ROW_W-1:0] a);
    logic legal;
    legal = mopen[b];
    if (legal) push_beats(b, a, 8);
    drive_cmd(CMD_READ, b, a);
    for (int j = 0; j < CL + 10; j++) begin
      @(negedge clk);
      chk($sformatf("rd_oe_t%0d", j), dq_oe,
          legal && j >= CL && j <= CL + 7);
      chk($sformatf("rd_soe_t%0d", j), dqs_oe,
          legal && j >= CL - 1 && j <= CL + 7);
      if (legal && j == CL - 1) chk("rd_preamble", dqs_out, 2'b00);
    end
    chk("rd_sb_drained", sb.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic [7:0][15:0] d1, d2, dr, d3, d4;
    logic [7:0][1:0] dz, dmm, dmr;

    cs_n = 1'b1; {ras_n, cas_n, we_n} = CMD_NOP;
    ba = 2'd0; addr = '0; dq_in = 16'h0; dm_in = 2'b00;
    for (int b = 0; b < 4; b++) begin mopen[b] = 1'b0; mrow[b] = '0; end

    for (int k = 0; k < 8; k++) begin
      d1[k] = 16'(16'h1111 * (k + 1));
      dr[k] = 16'($urandom);
      d3[k] = 16'($urandom);
      d4[k] = 16'($urandom);
      dmr[k] = 2'($urandom);
    end
    dz = '0;
    d2 = d1;
    d2[2] = 16'hABCD;
    dmm = '0;
    dmm[2] = 2'b10;

    vecs[0]  = mk(OP_ACT, 2'd1, 13'h0055, dz, dz, 4'b0000);
    vecs[1]  = mk(OP_WR,  2'd1, 13'h0010, d1, dz, 4'b0000);
    vecs[2]  = mk(OP_RD,  2'd1, 13'h0010, dz, dz, 4'b0000);
    vecs[3]  = mk(OP_WR,  2'd1, 13'h0010, d2, dmm, 4'b0000);
    vecs[4]  = mk(OP_RD,  2'd1, 13'h0010, dz, dz, 4'b0000);
    vecs[5]  = mk(OP_ACT, 2'd0, 13'h01AB, dz, dz, 4'b0000);
    vecs[6]  = mk(OP_WR,  2'd0, 13'h03F8, dr, dmr, 4'b0000);
    vecs[7]  = mk(OP_RD,  2'd0, 13'h03F8, dz, dz, 4'b0000);
    vecs[8]  = mk(OP_ACT, 2'd1, 13'h0066, dz, dz, 4'b0010);
    vecs[9]  = mk(OP_RD,  2'd1, 13'h0010, dz, dz, 4'b0010);
    vecs[10] = mk(OP_PRE, 2'd0, 13'h0400, dz, dz, 4'b0010);
    vecs[11] = mk(OP_REF, 2'd0, 13'h0000, dz, dz, 4'b0010);
    vecs[12] = mk(OP_RD,  2'd2, 13'h0100, dz, dz, 4'b0011);
    vecs[13] = mk(OP_ACT, 2'd2, 13'h0001, dz, dz, 4'b0011);
    vecs[14] = mk(OP_WR,  2'd2, 13'h0100, d3, dz, 4'b0011);
    vecs[15] = mk(OP_REF, 2'd0, 13'h0000, dz, dz, 4'b1011);

    repeat (3) @(negedge clk);
    chk("rst_dq", dq_out, 16'h0);
    chk("rst_dq_oe", dq_oe, 1'b0);
    chk("rst_dqs", dqs_out, 2'b00);
    chk("rst_dqs_oe", dqs_oe, 1'b0);
    chk("rst_err", err, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      case (v.op)
        OP_ACT: begin
          mopen[v.ba] = 1'b1;
          mrow[v.ba] = v.adr;
          drive_cmd(CMD_ACT, v.ba, v.adr);
        end
        OP_PRE: begin
          if (v.adr[10]) for (int b = 0; b < 4; b++) mopen[b] = 1'b0;
          else mopen[v.ba] = 1'b0;
          drive_cmd(CMD_PRE, v.ba, v.adr);
        end
        OP_REF: drive_cmd(CMD_REF, v.ba, v.adr);
        OP_WR: do_write(v.ba, v.adr, v.data, v.dm, -1);
        default: do_read(v.ba, v.adr);
      endcase
      @(negedge clk);
      chk($sformatf("vec%0d_err", i), err, v.exp_err);
    end

    // READ landing on the last read beat is refused
    push_beats(2'd2, 13'h0100, 8);
    drive_cmd(CMD_READ, 2'd2, 13'h0100);
    for (int j = 0; j < CL + 13; j++) begin
      @(negedge clk);
      if (j == CL + 7) begin
        cs_n = 1'b0;
        {ras_n, cas_n, we_n} = CMD_READ;
      end
      if (j == CL + 8) begin
        cs_n = 1'b1;
        {ras_n, cas_n, we_n} = CMD_NOP;
        chk("lastbeat_err", err, 4'b1111);
      end
      if (j >= CL + 8) chk($sformatf("lastbeat_oe_t%0d", j), dq_oe, 1'b0);
    end
    chk("lastbeat_sb", sb.size(), 0);

    // ACT during a write burst is dropped
    do_write(2'd2, 13'h0100, d4, dz, 3);
    @(negedge clk);
    chk("actbusy_err", err, 4'b1111);
    do_read(2'd3, 13'h0000);
    do_read(2'd2, 13'h0100);

    // reset on read beat 3
    push_beats(2'd2, 13'h0100, 4);
    drive_cmd(CMD_READ, 2'd2, 13'h0100);
    repeat (CL + 4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_dq_oe", dq_oe, 1'b0);
    chk("midrst_dqs_oe", dqs_oe, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int b = 0; b < 4; b++) mopen[b] = 1'b0;
    @(negedge clk);
    chk("midrst_err", err, 4'b0000);
    chk("midrst_sb", sb.size(), 0);
    do_read(2'd2, 13'h0100);
    @(negedge clk);
    chk("midrst_closed_err", err, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
